addsub_chunked: RTL

//  Parametrised multi-cycle adder/subtractor for the floating-point datapath (exponent add/bias

---
 rtl/addsub_chunked.sv | 107 ++++++++++
 1 files changed

// File: rtl/addsub_chunked.sv
// Multi-cycle chunked adder/subtractor: one CHUNK-bit ripple slice per clock, carry held in a register.
// Optional macro ADDSUB_OVF_EN adds the o_overflow port (signed two's-complement overflow).
module addsub_chunked #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_one,
    input  logic [WIDTH-1:0] i_data_two,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
`ifdef ADDSUB_OVF_EN
    ,
    output logic             o_overflow
`endif
);
    localparam int NUM_CHUNKS = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int IDXW       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CHUNKS - 1);

    generate
        if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
            $error("addsub_chunked: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;      // B already inverted for subtract
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;

    int                w_base;
    logic [CHUNK-1:0]  w_a_sl;
    logic [CHUNK-1:0]  w_b_sl;
    logic [CHUNK-1:0]  w_sum;
    logic              w_cout;

    always_comb begin
        w_base = CHUNK * int'(r_idx);
        w_a_sl = r_a[w_base +: CHUNK];
        w_b_sl = r_b[w_base +: CHUNK];
        {w_cout, w_sum} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_carry    <= 1'b0;
`ifdef ADDSUB_OVF_EN
            o_overflow <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_a     <= i_data_one;
                        r_b     <= i_data_two ^ {WIDTH{i_sub}};
                        r_carry <= i_sub;
                        r_idx   <= '0;
                        o_ready <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    o_data[w_base +: CHUNK] <= w_sum;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        o_carry <= w_cout;
`ifdef ADDSUB_OVF_EN
                        // the final slice holds the MSB, so w_sum's top bit is the result sign
                        o_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                      (w_sum[CHUNK-1] != r_a[WIDTH-1]);
`endif
                        o_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // ready rises only after the handshake, so no accept can share this cycle
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
